// File: rtl/blastit_cmd_pkg.sv
// Shared constants and types for the blastit UART command decoder:
// frame sync byte, opcodes, FSM state encoding and brightness reset value.
package blastit_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam logic [7:0] OP_SSEG_WR     = 8'h01;
    localparam logic [7:0] OP_SSEG_BRIGHT = 8'h02;
    localparam logic [7:0] OP_LEDS_WR     = 8'h03;
    localparam logic [7:0] OP_LEDS_BRIGHT = 8'h04;
    localparam logic [7:0] OP_WARN        = 8'h05;

    localparam logic [7:0] BRIGHT_RESET   = 8'h80;
    localparam logic [7:0] ERR_COUNT_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ARG0,
        ST_ARG1,
        ST_CHK
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_SSEG_WR)     || (op == OP_SSEG_BRIGHT) ||
               (op == OP_LEDS_WR)     || (op == OP_LEDS_BRIGHT) ||
               (op == OP_WARN);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Loadable down-counter used as the inter-byte timeout; expire_c pulses for
// one cycle on the last enabled count before reaching zero.
module cmd_timeout_timer #(
    parameter int unsigned               TIMEOUT_BITS   = 20,
    parameter logic [TIMEOUT_BITS-1:0]   TIMEOUT_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    logic [TIMEOUT_BITS-1:0] count_q;

    // A load always wins over counting so an arriving byte can never expire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= TIMEOUT_CYCLES;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - TIMEOUT_BITS'(1);
        end
    end

    assign expire_c = en && !load && (count_q == TIMEOUT_BITS'(1));

endmodule

// File: rtl/blastit_cmd_decoder.sv
// UART command decoder: frames A5/CMD/ARG0/ARG1/CHK, drives display write strobes
// and brightness registers. Inter-byte timeout enabled by BLASTIT_CMD_TIMEOUT_EN.
module blastit_cmd_decoder
    import blastit_cmd_pkg::*;
#(
    parameter int unsigned             SSEG_BITS      = 4,
    parameter int unsigned             PWM_BITS       = 8,
    parameter int unsigned             LEDS_N_BITS    = 4,
    parameter int unsigned             LEDS_M_BITS    = 4,
    parameter int unsigned             TIMEOUT_BITS   = 20,
    parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_done_tick,
    output logic                               sseg_wr,
    output logic [SSEG_BITS-1:0]               sseg_sel,
    output logic                               sseg_en,
    output logic                               sseg_sign,
    output logic                               sseg_dp,
    output logic [3:0]                         sseg_val,
    output logic [PWM_BITS-1:0]                sseg_brightness,
    output logic                               leds_wr,
    output logic [LEDS_N_BITS+LEDS_M_BITS-1:0] leds_sel_addr,
    output logic                               leds_sel,
    output logic                               leds_en,
    output logic [PWM_BITS-1:0]                leds_brightness,
    output logic [PWM_BITS-1:0]                warn_brightness,
    output logic                               warn_en,
    output logic                               frame_ok_tick,
    output logic [7:0]                         err_count
);

    localparam int unsigned LED_ADDR_W = LEDS_N_BITS + LEDS_M_BITS;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cmd_q;
    logic [7:0] arg0_q;
    logic [6:0] arg1_q;
    logic [7:0] chk_acc_q;
    logic       accept_c;
    logic       reject_c;
    logic       timeout_c;

`ifdef BLASTIT_CMD_TIMEOUT_EN
    cmd_timeout_timer #(
        .TIMEOUT_BITS   (TIMEOUT_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (rx_done_tick),
        .en       (state_q != ST_IDLE),
        .expire_c (timeout_c)
    );
`else
    logic [TIMEOUT_BITS-1:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_c             = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An A5 inside a frame is plain data; only IDLE looks for sync.
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = ST_IDLE;
        end else if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: if (rx_data == SYNC_BYTE) state_d = ST_CMD;
                ST_CMD:  state_d = ST_ARG0;
                ST_ARG0: state_d = ST_ARG1;
                ST_ARG1: state_d = ST_CHK;
                ST_CHK:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept_c = 1'b0;
        reject_c = 1'b0;
        if ((state_q == ST_CHK) && rx_done_tick) begin
            if ((chk_acc_q == rx_data) && op_known(cmd_q)) begin
                accept_c = 1'b1;
            end else begin
                reject_c = 1'b1;
            end
        end
        if (timeout_c) begin
            reject_c = 1'b1;
        end
    end

    // Payload capture with a running XOR so ARG1 bit 7 need not be stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= '0;
            arg0_q    <= '0;
            arg1_q    <= '0;
            chk_acc_q <= '0;
        end else if (rx_done_tick) begin
            case (state_q)
                ST_CMD: begin
                    cmd_q     <= rx_data;
                    chk_acc_q <= rx_data;
                end
                ST_ARG0: begin
                    arg0_q    <= rx_data;
                    chk_acc_q <= chk_acc_q ^ rx_data;
                end
                ST_ARG1: begin
                    arg1_q    <= rx_data[6:0];
                    chk_acc_q <= chk_acc_q ^ rx_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sseg_wr         <= 1'b0;
            sseg_sel        <= '0;
            sseg_en         <= 1'b0;
            sseg_sign       <= 1'b0;
            sseg_dp         <= 1'b0;
            sseg_val        <= '0;
            sseg_brightness <= PWM_BITS'(BRIGHT_RESET);
            leds_wr         <= 1'b0;
            leds_sel_addr   <= '0;
            leds_sel        <= 1'b0;
            leds_en         <= 1'b0;
            leds_brightness <= PWM_BITS'(BRIGHT_RESET);
            warn_brightness <= '0;
            warn_en         <= 1'b0;
            frame_ok_tick   <= 1'b0;
            err_count       <= '0;
        end else begin
            sseg_wr       <= 1'b0;
            leds_wr       <= 1'b0;
            frame_ok_tick <= accept_c;
            if (accept_c) begin
                case (cmd_q)
                    OP_SSEG_WR: begin
                        sseg_wr   <= 1'b1;
                        sseg_sel  <= SSEG_BITS'(arg0_q);
                        sseg_en   <= arg1_q[6];
                        sseg_sign <= arg1_q[5];
                        sseg_dp   <= arg1_q[4];
                        sseg_val  <= arg1_q[3:0];
                    end
                    OP_SSEG_BRIGHT: sseg_brightness <= PWM_BITS'(arg0_q);
                    OP_LEDS_WR: begin
                        leds_wr       <= 1'b1;
                        leds_sel_addr <= LED_ADDR_W'(arg0_q);
                        leds_sel      <= arg1_q[1];
                        leds_en       <= arg1_q[0];
                    end
                    OP_LEDS_BRIGHT: leds_brightness <= PWM_BITS'(arg0_q);
                    OP_WARN: begin
                        warn_brightness <= PWM_BITS'(arg0_q);
                        warn_en         <= arg1_q[0];
                    end
                    default: ;
                endcase
            end
            if (reject_c && (err_count != ERR_COUNT_MAX)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_blastit_cmd_decoder.sv
// Scoreboard bench for blastit_cmd_decoder: frames are modelled when driven,
// expected strobe snapshots are queued and compared when the DUT strobes.
`timescale 1ns/1ps
module tb_blastit_cmd_decoder;

    localparam int unsigned TO_CYC = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       sseg_wr;
    logic [3:0] sseg_sel;
    logic       sseg_en, sseg_sign, sseg_dp;
    logic [3:0] sseg_val;
    logic [7:0] sseg_brightness;
    logic       leds_wr;
    logic [7:0] leds_sel_addr;
    logic       leds_sel, leds_en;
    logic [7:0] leds_brightness;
    logic [7:0] warn_brightness;
    logic       warn_en;
    logic       frame_ok_tick;
    logic [7:0] err_count;

    always #10 clk = ~clk;

    blastit_cmd_decoder #(
        .SSEG_BITS      (4),
        .PWM_BITS       (8),
        .LEDS_N_BITS    (4),
        .LEDS_M_BITS    (4),
        .TIMEOUT_BITS   (20),
        .TIMEOUT_CYCLES (20'(TO_CYC))
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_done_tick    (rx_done_tick),
        .sseg_wr         (sseg_wr),
        .sseg_sel        (sseg_sel),
        .sseg_en         (sseg_en),
        .sseg_sign       (sseg_sign),
        .sseg_dp         (sseg_dp),
        .sseg_val        (sseg_val),
        .sseg_brightness (sseg_brightness),
        .leds_wr         (leds_wr),
        .leds_sel_addr   (leds_sel_addr),
        .leds_sel        (leds_sel),
        .leds_en         (leds_en),
        .leds_brightness (leds_brightness),
        .warn_brightness (warn_brightness),
        .warn_en         (warn_en),
        .frame_ok_tick   (frame_ok_tick),
        .err_count       (err_count)
    );

    typedef struct packed {
        logic       sseg_wr;
        logic       leds_wr;
        logic [3:0] sseg_sel;
        logic       sseg_en;
        logic       sseg_sign;
        logic       sseg_dp;
        logic [3:0] sseg_val;
        logic [7:0] leds_sel_addr;
        logic       leds_sel;
        logic       leds_en;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model of the decoder's architectural state
    logic [3:0] m_ssel;
    logic       m_sen, m_ssign, m_sdp;
    logic [3:0] m_sval;
    logic [7:0] m_laddr;
    logic       m_lsel, m_len;
    logic [7:0] m_sbr, m_lbr, m_wbr;
    logic       m_wen;
    logic [7:0] m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ssel = '0; m_sen = 1'b0; m_ssign = 1'b0; m_sdp = 1'b0; m_sval = '0;
        m_laddr = '0; m_lsel = 1'b0; m_len = 1'b0;
        m_sbr = 8'h80; m_lbr = 8'h80; m_wbr = 8'h00; m_wen = 1'b0;
        m_err = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sseg_bright"}, 32'(sseg_brightness), 32'(m_sbr));
        check({tag, ".leds_bright"}, 32'(leds_brightness), 32'(m_lbr));
        check({tag, ".warn_bright"}, 32'(warn_brightness), 32'(m_wbr));
        check({tag, ".warn_en"},     32'(warn_en),         32'(m_wen));
        check({tag, ".err_count"},   32'(err_count),       32'(m_err));
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        idle(2);
        model_reset();
        check("rst.sseg_wr",   32'(sseg_wr),       32'(0));
        check("rst.leds_wr",   32'(leds_wr),       32'(0));
        check("rst.frame_ok",  32'(frame_ok_tick), 32'(0));
        check("rst.sseg_sel",  32'(sseg_sel),      32'(m_ssel));
        check("rst.sseg_val",  32'(sseg_val),      32'(m_sval));
        check("rst.leds_addr", 32'(leds_sel_addr), 32'(m_laddr));
        check_regs("rst");
        reset = 1'b0;
        idle(1);
    endtask

    // Caller is aligned 1 time unit after a rising edge; gap 0 gives back-to-back ticks.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a0,
                              input logic [7:0] a1, input logic [7:0] chk, input int gap);
        exp_t e;
        logic good;
        good = (chk == (cmd ^ a0 ^ a1)) && (cmd >= 8'h01) && (cmd <= 8'h05);
        e = '0;
        if (good) begin
            case (cmd)
                8'h01: begin
                    m_ssel = a0[3:0]; m_sen = a1[6]; m_ssign = a1[5];
                    m_sdp = a1[4]; m_sval = a1[3:0]; e.sseg_wr = 1'b1;
                end
                8'h02: m_sbr = a0;
                8'h03: begin
                    m_laddr = a0; m_lsel = a1[1]; m_len = a1[0]; e.leds_wr = 1'b1;
                end
                8'h04: m_lbr = a0;
                default: begin
                    m_wbr = a0; m_wen = a1[0];
                end
            endcase
            e.sseg_sel = m_ssel; e.sseg_en = m_sen; e.sseg_sign = m_ssign;
            e.sseg_dp = m_sdp; e.sseg_val = m_sval;
            e.leds_sel_addr = m_laddr; e.leds_sel = m_lsel; e.leds_en = m_len;
            exp_q.push_back(e);
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
        send_byte(8'hA5, gap);
        send_byte(cmd, gap);
        send_byte(a0, gap);
        send_byte(a1, gap);
        send_byte(chk, gap);
    endtask

    task automatic send_good(input logic [7:0] cmd, input logic [7:0] a0,
                             input logic [7:0] a1, input int gap);
        send_frame(cmd, a0, a1, cmd ^ a0 ^ a1, gap);
    endtask

    // Strobe monitor: every strobe cycle must match the oldest queued frame.
    always @(negedge clk) begin
        if (!reset && (sseg_wr || leds_wr || frame_ok_tick)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({sseg_wr, leds_wr, frame_ok_tick}), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_ok_tick",  32'(frame_ok_tick), 32'(1));
                check("sseg_wr",        32'(sseg_wr),       32'(e.sseg_wr));
                check("leds_wr",        32'(leds_wr),       32'(e.leds_wr));
                check("sseg_sel",       32'(sseg_sel),      32'(e.sseg_sel));
                check("sseg_attr",      32'({sseg_en, sseg_sign, sseg_dp}),
                                        32'({e.sseg_en, e.sseg_sign, e.sseg_dp}));
                check("sseg_val",       32'(sseg_val),      32'(e.sseg_val));
                check("leds_sel_addr",  32'(leds_sel_addr), 32'(e.leds_sel_addr));
                check("leds_attr",      32'({leds_sel, leds_en}), 32'({e.leds_sel, e.leds_en}));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        #1;
        apply_reset();

        // Digit write: sel 3, en 1, sign 0, dp 1, val F
        send_good(8'h01, 8'h03, 8'h5F, 2);
        idle(2);
        check("sseg1.sel", 32'(sseg_sel), 32'(4'h3));
        check("sseg1.val", 32'(sseg_val), 32'(4'hF));
        check_regs("sseg1");

        // LED write with wrong checksum, then a correct one
        send_frame(8'h03, 8'h27, 8'h03, 8'h24, 2);
        idle(2);
        check_regs("bad_chk");
        send_good(8'h03, 8'h27, 8'h03, 2);
        idle(2);
        check_regs("leds_wr");

        // Good checksum, unknown opcode
        send_good(8'h07, 8'h11, 8'h22, 2);
        idle(2);
        check_regs("bad_op");

        // Leading junk, then brightness and warning registers
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_frame(8'h02, 8'h40, 8'h00, 8'h42, 1);
        idle(2);
        check_regs("junk_bright");
        send_good(8'h05, 8'h33, 8'h01, 1);
        idle(2);
        check_regs("warn");

        // A5 inside a frame is data, not a resync
        send_good(8'h01, 8'hA5, 8'h25, 1);
        idle(2);
        check("a5_data.sel", 32'(sseg_sel), 32'(4'h5));

        // Back-to-back frames: second SYNC lands in the first frame's strobe cycle
        send_good(8'h01, 8'h0A, 8'h47, 0);
        send_good(8'h01, 8'h0B, 8'h1C, 0);
        idle(3);
        check_regs("b2b");

        // Saturating error counter
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h03, 8'h27, 8'h03, 8'h24, 0);
        end
        idle(2);
        check_regs("err_sat");

        // Reset mid-frame aborts it
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        apply_reset();
        send_frame(8'h04, 8'h10, 8'h00, 8'h14, 1);
        idle(2);
        check_regs("post_reset");

        // Partial frame left idle past the timeout window
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        idle(TO_CYC + 50);
`ifdef BLASTIT_CMD_TIMEOUT_EN
        m_err = m_err + 8'd1;
`endif
        check_regs("timeout");
`ifndef BLASTIT_CMD_TIMEOUT_EN
        apply_reset();
`endif
        send_good(8'h01, 8'h06, 8'h6A, 2);
        idle(2);
        check("after_to.sel", 32'(sseg_sel), 32'(4'h6));
        check_regs("after_to");

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
